ascon_round_sequencer: RTL

//   Counts Ascon permutation rounds upward and issues one round constant per accepted round.

---
 rtl/ascon_round_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/ascon_round_sequencer.sv
// Ascon permutation round sequencer: walks the round index up to MAX_ROUNDS-1 and
// issues one round constant per valid/ready handshake with the round datapath.
module ascon_round_sequencer #(
    parameter int unsigned MAX_ROUNDS = 12,
    parameter int unsigned IDX_WIDTH  = 4,
    parameter bit          DONE_HOLD  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [IDX_WIDTH-1:0] rounds_i,
    input  logic                 abort_i,
    output logic                 ready_o,
    output logic                 err_o,
    output logic                 round_valid_o,
    input  logic                 round_ready_i,
    output logic [7:0]           rc_o,
    output logic [IDX_WIDTH-1:0] round_idx_o,
    output logic                 last_round_o,
    output logic                 done_o,
    input  logic                 done_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [IDX_WIDTH-1:0] MAX_IDX  = IDX_WIDTH'(MAX_ROUNDS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(MAX_ROUNDS - 1);

    state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 err_q, err_d;
    logic                 rounds_ok;
    logic                 in_run;

    assign rounds_ok = (rounds_i != '0) && (rounds_i <= MAX_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; abort overrides every normal transition
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (rounds_ok) begin
                            state_d = S_RUN;
                            idx_d   = MAX_IDX - rounds_i;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // An index past the last round can only come from corruption
                    if (idx_q > LAST_IDX) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else if (round_ready_i) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d = idx_q + IDX_WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (!DONE_HOLD || done_ack_i) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Outputs decode registered state only
    assign in_run        = (state_q == S_RUN);
    assign ready_o       = (state_q == S_IDLE);
    assign err_o         = err_q;
    assign round_valid_o = in_run;
    assign done_o        = (state_q == S_DONE);
    assign round_idx_o   = idx_q;
    assign rc_o          = in_run ? {4'hF - idx_q[3:0], idx_q[3:0]} : 8'h00;
    assign last_round_o  = in_run && (idx_q == LAST_IDX);

endmodule
